sum_5bit: RTL and testbench

SUM_5BIT -- requirements
Module: sum_5bit

---
 rtl/kgp_pkg.sv | 31 +++
 rtl/kgp_combine.sv | 12 +
 rtl/sum_5bit.sv | 72 +++++++
 tb/tb_sum_5bit.sv | 136 +++++++++++++
 4 files changed

// File: rtl/kgp_pkg.sv
// Shared kill/generate/propagate carry-status encoding and the prefix combine rule.
package kgp_pkg;

  typedef logic [1:0] kgp_t;

  localparam kgp_t KGP_KILL = 2'b00;
  localparam kgp_t KGP_GEN  = 2'b11;
  localparam kgp_t KGP_PROP = 2'b01;

  // hi is the higher-order span; it only defers to lo when it propagates.
  function automatic kgp_t kgp_merge(input kgp_t hi, input kgp_t lo);
    kgp_t res;
    if (hi == KGP_KILL)
      res = KGP_KILL;
    else if (hi == KGP_GEN)
      res = KGP_GEN;
    else
      res = lo;
    return res;
  endfunction

  function automatic kgp_t kgp_from_bits(input logic a, input logic b);
    kgp_t res;
    if (a != b)
      res = KGP_PROP;
    else
      res = a ? KGP_GEN : KGP_KILL;
    return res;
  endfunction

endpackage

// File: rtl/kgp_combine.sv
// Combinational two-input KGP operator: one node of the carry prefix tree.
module kgp_combine
  import kgp_pkg::*;
(
  input  kgp_t hi,
  input  kgp_t lo,
  output kgp_t res
);

  assign res = kgp_merge(hi, lo);

endmodule

// File: rtl/sum_5bit.sv
// Unsigned adder with KGP-encoded carry-in, Kogge-Stone carry prefix and one output register.
module sum_5bit
  import kgp_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       kIn,
  input  logic             in_valid,
  output logic [WIDTH:0]   sum,
  output logic             out_valid
);

  // Position 0 holds the carry-in seed, position j+1 holds bit j.
  localparam int N      = WIDTH + 1;
  localparam int LEVELS = $clog2(N);

  logic [WIDTH:0] carry;
  logic [WIDTH:0] sum_d;
  logic [WIDTH:0] sum_p1;
  logic           vld_p1;

  for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
    kgp_t node [N];
    if (k == 0) begin : g_seed
      assign node[0] = kIn;
      for (genvar j = 0; j < WIDTH; j++) begin : g_bit
        assign node[j+1] = kgp_from_bits(a[j], b[j]);
      end
    end else begin : g_comb
      localparam int SPAN = 1 << (k - 1);
      for (genvar j = 0; j < N; j++) begin : g_node
        if (j >= SPAN) begin : g_op
          kgp_combine u_comb (
            .hi  (g_lvl[k-1].node[j]),
            .lo  (g_lvl[k-1].node[j-SPAN]),
            .res (node[j])
          );
        end else begin : g_pass
          assign node[j] = g_lvl[k-1].node[j];
        end
      end
    end
  end

  // Prefix ending at position i spans the seed through bit i-1: the carry into bit i.
  // A fully propagating span has no upstream carry, so only generate yields 1.
  for (genvar i = 0; i <= WIDTH; i++) begin : g_carry
    assign carry[i] = (g_lvl[LEVELS].node[i] == KGP_GEN);
  end

  assign sum_d = {carry[WIDTH], (a ^ b ^ carry[WIDTH-1:0])};

  // Stage p1: output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid)
        sum_p1 <= sum_d;
    end
  end

  assign sum       = sum_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_sum_5bit.sv
// Self-checking bench for sum_5bit: directed table, hand sequences and a shuffled exhaustive sweep.
module tb_sum_5bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] a;
  logic [4:0] b;
  logic [1:0] kIn;
  logic       in_valid;
  logic [5:0] sum;
  logic       out_valid;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [4:0] a;
    logic [4:0] b;
    logic [1:0] k;
    int         exp;
  } vec_t;

  vec_t vecs [$];
  int   order [4096];
  int   last_sum;

  sum_5bit #(.WIDTH(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .kIn       (kIn),
    .in_valid  (in_valid),
    .sum       (sum),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  function automatic int model(input int x, input int y, input int k);
    return x + y + ((k == 3) ? 1 : 0);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge that registers them.
  task automatic step(input logic [4:0] x, input logic [4:0] y, input logic [1:0] k, input logic v);
    a = x; b = y; kIn = k; in_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; a = 5'd3; b = 5'd4; kIn = 2'b11; in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_sum", sum, 0);
    check("reset_valid", out_valid, 0);
    rst_n = 1'b1;

    vecs.push_back('{"dir_34",       5'b10111, 5'b01011, 2'b00, 34});
    vecs.push_back('{"max_gen",      5'd31,    5'd31,    2'b11, 63});
    vecs.push_back('{"max_kill",     5'd31,    5'd31,    2'b00, 62});
    vecs.push_back('{"zero_gen",     5'd0,     5'd0,     2'b11, 1});
    vecs.push_back('{"prop01",       5'd5,     5'd3,     2'b01, 8});
    vecs.push_back('{"prop10",       5'd5,     5'd3,     2'b10, 8});
    vecs.push_back('{"all_prop10",   5'd21,    5'd10,    2'b10, 31});
    vecs.push_back('{"all_prop_gen", 5'd21,    5'd10,    2'b11, 32});
    foreach (vecs[i]) begin
      step(vecs[i].a, vecs[i].b, vecs[i].k, 1'b1);
      check({vecs[i].name, "_sum"}, sum, vecs[i].exp);
      check({vecs[i].name, "_valid"}, out_valid, 1);
    end

    step(5'd9, 5'd9, 2'b11, 1'b0);
    check("hold_sum", sum, 32);
    check("hold_valid", out_valid, 0);

    step(5'd1, 5'd1, 2'b00, 1'b1);
    check("b2b0_sum", sum, 2);
    check("b2b0_valid", out_valid, 1);
    step(5'd15, 5'd16, 2'b11, 1'b1);
    check("b2b1_sum", sum, 32);
    check("b2b1_valid", out_valid, 1);
    step(5'd31, 5'd0, 2'b00, 1'b1);
    check("b2b2_sum", sum, 31);
    check("b2b2_valid", out_valid, 1);

    rst_n = 1'b0;
    step(5'd7, 5'd9, 2'b11, 1'b1);
    check("midrst_sum", sum, 0);
    check("midrst_valid", out_valid, 0);
    rst_n = 1'b1;
    step(5'd7, 5'd9, 2'b11, 1'b1);
    check("post_rst_sum", sum, 17);
    check("post_rst_valid", out_valid, 1);
    last_sum = 17;

    for (int i = 0; i < 4096; i++) order[i] = i;
    for (int i = 4095; i > 0; i--) begin
      int j;
      int t;
      j = $urandom_range(i, 0);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 4096; i++) begin
      int x;
      int y;
      int k;
      x = order[i] & 31;
      y = (order[i] >> 5) & 31;
      k = (order[i] >> 10) & 3;
      if ($urandom_range(7, 0) == 0) begin
        step(5'($urandom), 5'($urandom), 2'($urandom), 1'b0);
        check("sweep_idle_sum", sum, last_sum);
        check("sweep_idle_valid", out_valid, 0);
      end
      step(5'(x), 5'(y), 2'(k), 1'b1);
      last_sum = model(x, y, k);
      check("sweep_sum", sum, last_sum);
      check("sweep_valid", out_valid, 1);
    end

    in_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
